// File: rtl/conv_scan_pkg.sv
// conv_scan_pkg: shared types for the convolution scan controller.
//   state_e     - scan FSM states
//   res_t       - captured result record at the default widths
//   COORD_W_DEF - default coordinate width
//   RES_W_DEF   - default result width
package conv_scan_pkg;

  localparam int COORD_W_DEF = 24;
  localparam int RES_W_DEF   = 171;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [RES_W_DEF-1:0]   data;
    logic [COORD_W_DEF-1:0] row;
    logic [COORD_W_DEF-1:0] col;
    logic                   last;
  } res_t;

endpackage

// File: rtl/conv_scan_cnt.sv
// conv_scan_cnt: 2-D raster position counter with a fixed stride.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   load             - latch rows_in/cols_in and restart at (0,0)
//   step             - advance to the next raster position
//   rows_in, cols_in - grid dimensions sampled on load
//   row, col         - current position
//   last             - current position is the final one of the grid
module conv_scan_cnt
  import conv_scan_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int STRIDE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] rows_in,
  input  logic [COORD_W-1:0] cols_in,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);

  localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STRIDE);

  logic [COORD_W-1:0] rows_r;
  logic [COORD_W-1:0] cols_r;
  logic [COORD_W-1:0] row_r;
  logic [COORD_W-1:0] col_r;
  logic [COORD_W:0]   col_nxt_s;
  logic [COORD_W:0]   row_nxt_s;
  logic               col_wrap_s;
  logic               row_end_s;

  // Next position computed one bit wider so a stride near the top of the range cannot wrap.
  always_comb begin
    col_nxt_s  = {1'b0, col_r} + STEP_W;
    row_nxt_s  = {1'b0, row_r} + STEP_W;
    col_wrap_s = (col_nxt_s >= {1'b0, cols_r});
    row_end_s  = (row_nxt_s >= {1'b0, rows_r});
  end

  // Dimension latch and raster position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_r <= {COORD_W{1'b0}};
      cols_r <= {COORD_W{1'b0}};
      row_r  <= {COORD_W{1'b0}};
      col_r  <= {COORD_W{1'b0}};
    end else if (load) begin
      rows_r <= rows_in;
      cols_r <= cols_in;
      row_r  <= {COORD_W{1'b0}};
      col_r  <= {COORD_W{1'b0}};
    end else if (step) begin
      if (col_wrap_s) begin
        col_r <= {COORD_W{1'b0}};
        row_r <= row_nxt_s[COORD_W-1:0];
      end else begin
        col_r <= col_nxt_s[COORD_W-1:0];
      end
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign last = col_wrap_s & row_end_s;

endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: walks an output grid in raster order, issues one request per
// position to the conv engine, and forwards each result on a valid/ready channel.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   cfg_go, cfg_rows, cfg_cols  - scan command and grid size (accepted only when idle)
//   busy, done                  - scan in progress / one-cycle completion pulse
//   start, row, col             - request to the engine
//   o_valid, o                  - engine result
//   res_valid, res_ready        - downstream handshake
//   res_data, res_row, res_col, res_last - captured result and its tags
//   err_timeout                 - sticky reply timeout (only with CONV_SCAN_TIMEOUT_EN)
// Build option: define CONV_SCAN_TIMEOUT_EN to bound the wait for o_valid by
// TIMEOUT_CYCLES; the scan then ends early with err_timeout set.
module conv_scan_ctrl
  import conv_scan_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int STRIDE  = 1
`ifdef CONV_SCAN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_go,
  input  logic [COORD_W-1:0] cfg_rows,
  input  logic [COORD_W-1:0] cfg_cols,
  output logic               busy,
  output logic               done,
  output logic               start,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  input  logic               o_valid,
  input  logic [RES_W-1:0]   o,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   res_data,
  output logic [COORD_W-1:0] res_row,
  output logic [COORD_W-1:0] res_col,
  output logic               res_last
`ifdef CONV_SCAN_TIMEOUT_EN
  , output logic             err_timeout
`endif
);

`ifdef CONV_SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt_r;
  logic            err_timeout_r;
`endif

  state_e             state_r;
  logic               busy_r;
  logic               done_r;
  logic               start_r;
  logic               res_valid_r;
  logic [RES_W-1:0]   res_data_r;
  logic [COORD_W-1:0] res_row_r;
  logic [COORD_W-1:0] res_col_r;
  logic               res_last_r;

  logic               load_s;
  logic               step_s;
  logic               hshake_s;
  logic               dims_zero_s;
  logic               cnt_last_s;
  logic [COORD_W-1:0] cnt_row_s;
  logic [COORD_W-1:0] cnt_col_s;

  // Counter control: load on an accepted go, step on a non-final handshake.
  always_comb begin
    load_s      = 1'b0;
    step_s      = 1'b0;
    hshake_s    = res_valid_r & res_ready;
    dims_zero_s = (cfg_rows == {COORD_W{1'b0}}) || (cfg_cols == {COORD_W{1'b0}});
    if (state_r == IDLE) begin
      load_s = cfg_go;
    end else if (state_r == HOLD) begin
      step_s = hshake_s & ~cnt_last_s;
    end else begin
      load_s = 1'b0;
      step_s = 1'b0;
    end
  end

  conv_scan_cnt #(
    .COORD_W (COORD_W),
    .STRIDE  (STRIDE)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .step    (step_s),
    .rows_in (cfg_rows),
    .cols_in (cfg_cols),
    .row     (cnt_row_s),
    .col     (cnt_col_s),
    .last    (cnt_last_s)
  );

  // Scan FSM with registered strobes and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      start_r     <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {RES_W{1'b0}};
      res_row_r   <= {COORD_W{1'b0}};
      res_col_r   <= {COORD_W{1'b0}};
      res_last_r  <= 1'b0;
`ifdef CONV_SCAN_TIMEOUT_EN
      wait_cnt_r    <= {TO_W{1'b0}};
      err_timeout_r <= 1'b0;
`endif
    end else begin
      start_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_go) begin
            busy_r <= 1'b1;
`ifdef CONV_SCAN_TIMEOUT_EN
            err_timeout_r <= 1'b0;
`endif
            // An empty grid still produces a busy cycle and a done pulse.
            if (dims_zero_s) begin
              state_r <= FIN;
            end else begin
              start_r <= 1'b1;
              state_r <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_r <= WAIT;
`ifdef CONV_SCAN_TIMEOUT_EN
          wait_cnt_r <= {TO_W{1'b0}};
`endif
        end
        WAIT: begin
          if (o_valid) begin
            res_valid_r <= 1'b1;
            res_data_r  <= o;
            res_row_r   <= cnt_row_s;
            res_col_r   <= cnt_col_s;
            res_last_r  <= cnt_last_s;
            state_r     <= HOLD;
          end else begin
`ifdef CONV_SCAN_TIMEOUT_EN
            if (wait_cnt_r == TO_LAST) begin
              err_timeout_r <= 1'b1;
              state_r       <= FIN;
            end else begin
              wait_cnt_r <= wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
`endif
          end
        end
        HOLD: begin
          if (hshake_s) begin
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            if (cnt_last_s) begin
              state_r <= FIN;
            end else begin
              start_r <= 1'b1;
              state_r <= ISSUE;
            end
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          res_valid_r <= 1'b0;
          res_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign start     = start_r;
  assign row       = cnt_row_s;
  assign col       = cnt_col_s;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_row   = res_row_r;
  assign res_col   = res_col_r;
  assign res_last  = res_last_r;
`ifdef CONV_SCAN_TIMEOUT_EN
  assign err_timeout = err_timeout_r;
`endif

endmodule
